// File: rtl/seq_const_mult.sv
// Sequential shift-add multiplier by a compile-time constant: product = a * CONST.
// One constant bit is scanned per clock; valid/ready handshake on both sides.
module seq_const_mult #(
  parameter int              WIDTH = 5,
  parameter int              CW    = 6,
  parameter logic [CW-1:0]   CONST = CW'(37),
  localparam int             PW    = WIDTH + CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    product,
  output logic             busy
);

  localparam int CNTW = $clog2(CW) + 1;
  localparam int CN   = 1 << CNTW;
  // Zero-padded copy of CONST so it can be indexed by the full-width counter.
  localparam logic [CN-1:0]   CPAD = {{(CN-CW){1'b0}}, CONST};
  localparam logic [CNTW-1:0] LAST = CNTW'(CW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_reg;
  logic [CNTW-1:0]  cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    term;

  always_comb begin
    term = '0;
    if (CPAD[cnt]) term = {{CW{1'b0}}, a_reg} << cnt;
  end

  assign product = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      a_reg     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg    <= a;
          acc      <= '0;
          cnt      <= '0;
          state    <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          acc <= acc + term;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_const_mult.sv
// Directed bench for seq_const_mult: default x37 instance plus 8x8 instances with CONST=255 and CONST=0.
module tb_seq_const_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv = 1'b0, ordy = 1'b1, ir, ov, bsy;
  logic [4:0]  a = '0;
  logic [10:0] p;

  logic        iv2 = 1'b0, ordy2 = 1'b1, ir2, ov2, bsy2, ir3, ov3, bsy3;
  logic [7:0]  a2 = '0;
  logic [15:0] p2, p3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovpulses = 0;
  int acc_cyc[$];

  seq_const_mult dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a),
    .out_valid(ov), .out_ready(ordy), .product(p), .busy(bsy));

  seq_const_mult #(.WIDTH(8), .CW(8), .CONST(8'd255)) dut_ff (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2),
    .out_valid(ov2), .out_ready(ordy2), .product(p2), .busy(bsy2));

  seq_const_mult #(.WIDTH(8), .CW(8), .CONST(8'd0)) dut_zero (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir3), .a(a2),
    .out_valid(ov3), .out_ready(ordy2), .product(p3), .busy(bsy3));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && iv && ir) acc_cyc.push_back(cyc);
    if (ov) ovpulses <= ovpulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept1(input logic [4:0] v);
    a  = v;
    iv = 1'b1;
    tick();
    iv = 1'b0;
  endtask

  task automatic wait_ov(output int lat);
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (ov) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ir, ov, bsy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got ir=%b ov=%b busy=%b want 1 0 0", ir, ov, bsy);
    end
    checks++;
    if (p !== 11'd0) begin
      errors++;
      $display("FAIL reset_product got %0d want 0", p);
    end
    checks++;
    if ({ir2, ov2, bsy2, ir3, ov3, bsy3} !== 6'b100100 || p2 !== 16'd0 || p3 !== 16'd0) begin
      errors++;
      $display("FAIL reset_wide got ir2=%b ov2=%b ir3=%b ov3=%b p2=%0d p3=%0d want 1 0 1 0 0 0",
               ir2, ov2, ir3, ov3, p2, p3);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    ordy = 1'b1;
    accept1(5'd5);
    wait_ov(lat);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL basic_latency got %0d want 6", lat);
    end
    checks++;
    if (p !== 11'd185 || bsy !== 1'b1 || ir !== 1'b0) begin
      errors++;
      $display("FAIL basic_product got %0d busy=%b ir=%b want 185 1 0", p, bsy, ir);
    end
    tick();
    checks++;
    if ({ir, ov, bsy} !== 3'b100) begin
      errors++;
      $display("FAIL basic_idle got ir=%b ov=%b busy=%b want 1 0 0", ir, ov, bsy);
    end
  endtask

  task automatic test_back_to_back();
    int n0, lat;
    logic got;
    logic [10:0] pv;
    got  = 1'b0;
    pv   = '0;
    ordy = 1'b1;
    n0   = acc_cyc.size();
    a    = 5'd31;
    iv   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ov && !got) begin
        got = 1'b1;
        pv  = p;
      end
      if (acc_cyc.size() >= n0 + 2) break;
    end
    iv = 1'b0;
    checks++;
    if (pv !== 11'd1147) begin
      errors++;
      $display("FAIL b2b_product got %0d want 1147", pv);
    end
    checks++;
    if (acc_cyc.size() < n0 + 2) begin
      errors++;
      $display("FAIL b2b_spacing got %0d accepts want 2", acc_cyc.size() - n0);
    end else if (acc_cyc[n0+1] - acc_cyc[n0] !== 8) begin
      errors++;
      $display("FAIL b2b_spacing got %0d cycles want 8", acc_cyc[n0+1] - acc_cyc[n0]);
    end
    wait_ov(lat);
    checks++;
    if (lat !== 6 || p !== 11'd1147) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d p=%0d want 6 1147", lat, p);
    end
    tick();
  endtask

  task automatic test_hold();
    int lat;
    ordy = 1'b0;
    accept1(5'd7);
    wait_ov(lat);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL hold_latency got %0d want 6", lat);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ov !== 1'b1 || p !== 11'd259 || ir !== 1'b0 || bsy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable cyc %0d got ov=%b p=%0d ir=%b busy=%b want 1 259 0 1",
                 i, ov, p, ir, bsy);
      end
      tick();
    end
    ordy = 1'b1;
    tick();
    checks++;
    if ({ir, ov, bsy} !== 3'b100) begin
      errors++;
      $display("FAIL hold_release got ir=%b ov=%b busy=%b want 1 0 0", ir, ov, bsy);
    end
  endtask

  task automatic test_ignore();
    int n0, lat;
    lat  = -1;
    ordy = 1'b1;
    n0   = acc_cyc.size();
    accept1(5'd9);
    for (int i = 1; i <= 50; i++) begin
      iv = ~iv;
      a  = 5'($urandom);
      tick();
      if (ov) begin
        iv  = 1'b0;
        lat = i;
        break;
      end
    end
    iv = 1'b0;
    checks++;
    if (lat !== 6 || p !== 11'd333) begin
      errors++;
      $display("FAIL ignore_product got lat=%0d p=%0d want 6 333", lat, p);
    end
    tick();
    tick();
    checks++;
    if (acc_cyc.size() - n0 !== 1) begin
      errors++;
      $display("FAIL ignore_accepts got %0d want 1", acc_cyc.size() - n0);
    end
  endtask

  task automatic test_reset_mid();
    int o0, lat;
    ordy = 1'b1;
    o0   = ovpulses;
    accept1(5'd3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ir, ov, bsy} !== 3'b100 || p !== 11'd0) begin
      errors++;
      $display("FAIL midrst_state got ir=%b ov=%b busy=%b p=%0d want 1 0 0 0", ir, ov, bsy, p);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (ovpulses !== o0) begin
      errors++;
      $display("FAIL midrst_nopulse got %0d pulses want 0", ovpulses - o0);
    end
    accept1(5'd1);
    wait_ov(lat);
    checks++;
    if (lat !== 6 || p !== 11'd37) begin
      errors++;
      $display("FAIL midrst_next got lat=%0d p=%0d want 6 37", lat, p);
    end
    tick();
  endtask

  task automatic test_wide();
    int lat2, lat3;
    logic [15:0] pv2, pv3;
    lat2  = -1;
    lat3  = -1;
    pv2   = '0;
    pv3   = 16'hffff;
    ordy2 = 1'b1;
    a2    = 8'd255;
    iv2   = 1'b1;
    tick();
    iv2   = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (ov2 && lat2 < 0) begin lat2 = i; pv2 = p2; end
      if (ov3 && lat3 < 0) begin lat3 = i; pv3 = p3; end
      if (lat2 >= 0 && lat3 >= 0) break;
    end
    checks++;
    if (lat2 !== 8 || pv2 !== 16'd65025) begin
      errors++;
      $display("FAIL wide_ff got lat=%0d p=%0d want 8 65025", lat2, pv2);
    end
    checks++;
    if (lat3 !== 8 || pv3 !== 16'd0) begin
      errors++;
      $display("FAIL wide_zero got lat=%0d p=%0d want 8 0", lat3, pv3);
    end
    tick();
    checks++;
    if ({ir2, bsy2, ir3, bsy3} !== 4'b1010) begin
      errors++;
      $display("FAIL wide_idle got ir2=%b busy2=%b ir3=%b busy3=%b want 1 0 1 0", ir2, bsy2, ir3, bsy3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_ignore();
    test_reset_mid();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
